// File: rtl/scmp_bus_ctl.sv
// scmp_bus_ctl -- SC/MP external bus cycle controller.
//
// Takes one bus request at a time from the microcode sequencer. It acquires
// the shared bus through the BREQ/ENIN/ENOUT daisy chain, then runs the cycle:
// one clock of address strobe, then a read or write strobe of STROBE_CYC
// clocks. req_ready pulses for one clock when the cycle is complete.
//
// Optional feature macro: SCMP_BUS_HOLD_EN
//   defined   -> bus_hold stretches the strobe through the WAIT state
//   undefined -> bus_hold is ignored and WAIT is never entered
//
// All bus-side outputs are registered. Each one is decoded from the state
// being entered. bus_enout is the only combinational output, because the
// daisy chain must pass the grant on within the same clock.
module scmp_bus_ctl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [3:0]        req_flags,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bus_breq_out,
    input  logic              bus_breq_in,
    input  logic              bus_enin,
    output logic              bus_enout,
    input  logic              bus_hold,
    output logic              bus_ads_n,
    output logic              bus_rd_n,
    output logic              bus_wr_n,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_flags,
    output logic [DATA_W-1:0] bus_dout,
    output logic              bus_doe,
    input  logic [DATA_W-1:0] bus_din
);

    // The strobe counter counts down from STROBE_CYC-1 to 0.
    localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_rd_reg;

    logic accept;
    logic strobe_last;
    logic owned_next;
    logic data_phase_next;
    logic strobe_next;

    // bus_breq_in only matters to external test logic.
    logic unused_inputs;

    // A request with neither direction bit set is ignored. Both bits set means read.
    assign accept = req_valid & (req_rd | req_wr);

`ifdef SCMP_BUS_HOLD_EN
    // The last low-strobe clock is the one whose edge leaves for DONE.
    assign strobe_last = ((state_reg == S_STROBE) && (cnt_reg == '0) && !bus_hold) ||
                         ((state_reg == S_WAIT) && !bus_hold);
    assign unused_inputs = bus_breq_in;
`else
    assign strobe_last = (state_reg == S_STROBE) && (cnt_reg == '0);
    assign unused_inputs = ^{bus_breq_in, bus_hold};
`endif

    // Next-state selection. bus_enin only matters while the bus is being requested.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_enin) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                state_next = S_STROBE;
            end
`ifdef SCMP_BUS_HOLD_EN
            S_STROBE: begin
                if (cnt_reg == '0) begin
                    state_next = bus_hold ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (!bus_hold) begin
                    state_next = S_DONE;
                end
            end
`else
            S_STROBE: begin
                if (cnt_reg == '0) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode for the state about to be entered, so the registered
    // outputs line up with the state register.
    always_comb begin
        owned_next      = (state_next != S_IDLE);
        data_phase_next = (state_next == S_ADDR) || (state_next == S_STROBE) ||
                          (state_next == S_WAIT) || (state_next == S_DONE);
        strobe_next     = (state_next == S_STROBE) || (state_next == S_WAIT);
    end

    // Cycle FSM: state, the latched request, the strobe counter and all registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            is_rd_reg    <= 1'b0;
            bus_addr     <= '0;
            bus_flags    <= '0;
            bus_dout     <= '0;
            rsp_rdata    <= '0;
            req_ready    <= 1'b0;
            bus_breq_out <= 1'b0;
            bus_ads_n    <= 1'b1;
            bus_rd_n     <= 1'b1;
            bus_wr_n     <= 1'b1;
            bus_doe      <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Capture the request at acceptance. The address and flags then
            // stay on the pins until the next request replaces them.
            if ((state_reg == S_IDLE) && accept) begin
                is_rd_reg <= req_rd;
                bus_addr  <= req_addr;
                bus_flags <= req_flags;
                bus_dout  <= req_wdata;
            end

            if (state_reg == S_ADDR) begin
                cnt_reg <= CNT_LOAD;
            end else if ((state_reg == S_STROBE) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end

            // Read data is taken on the final low-strobe clock and then held.
            if (strobe_last && is_rd_reg) begin
                rsp_rdata <= bus_din;
            end

            req_ready    <= (state_next == S_DONE);
            bus_breq_out <= owned_next;
            bus_ads_n    <= !(state_next == S_ADDR);
            bus_rd_n     <= !(strobe_next && is_rd_reg);
            bus_wr_n     <= !(strobe_next && !is_rd_reg);
            bus_doe      <= data_phase_next && !is_rd_reg;
        end
    end

    // Pass the daisy-chain grant downstream only while idle with nothing to do.
    assign bus_enout = bus_enin & (state_reg == S_IDLE) & ~req_valid & ~rst;

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Testbench for scmp_bus_ctl. It runs a scoreboard with a separate monitor,
// a bus-slave model and a randomized driver.
`timescale 1ns/1ps
module tb_scmp_bus_ctl;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int STROBE_CYC = 2;
`ifdef SCMP_BUS_HOLD_EN
    localparam int HOLD_EN = 1;
`else
    localparam int HOLD_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid, req_rd, req_wr;
    logic [3:0]        req_flags;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              bus_breq_out, bus_enin, bus_enout, bus_hold;
    logic              bus_ads_n, bus_rd_n, bus_wr_n, bus_doe;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_flags;
    logic [DATA_W-1:0] bus_dout, bus_din;

    always #5 clk = ~clk;

    scmp_bus_ctl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STROBE_CYC(STROBE_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
        .req_flags(req_flags), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_rdata(rsp_rdata),
        .bus_breq_out(bus_breq_out), .bus_breq_in(bus_breq_out),
        .bus_enin(bus_enin), .bus_enout(bus_enout), .bus_hold(bus_hold),
        .bus_ads_n(bus_ads_n), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n),
        .bus_addr(bus_addr), .bus_flags(bus_flags), .bus_dout(bus_dout),
        .bus_doe(bus_doe), .bus_din(bus_din)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outcome of one bus cycle, derived from the request and the slave plan.
    typedef struct {
        logic        is_rd;
        logic [7:0]  rdata;
        logic [15:0] addr;
        logic [3:0]  flags;
        logic [7:0]  wdata;
        int          nlow;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];

    // Slave plan: read data for each low-strobe clock, and the number of hold clocks.
    logic [7:0] din_plan [0:15];
    int         hold_plan = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: presents per-clock read data and asserts hold at the strobe end.
    initial begin : slave
        int low_cnt;
        int hold_left;
        low_cnt   = 0;
        hold_left = 0;
        bus_hold  = 1'b0;
        bus_din   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_cnt  = 0;
                bus_hold = 1'b0;
            end else if (!bus_rd_n || !bus_wr_n) begin
                if (low_cnt == 0) hold_left = hold_plan;
                bus_din = din_plan[(low_cnt < 16) ? low_cnt : 15];
                if (low_cnt >= STROBE_CYC - 1) begin
                    if (hold_left > 0) begin
                        bus_hold = 1'b1;
                        hold_left--;
                    end else begin
                        bus_hold = 1'b0;
                    end
                end else begin
                    bus_hold = 1'($urandom);
                end
                low_cnt++;
            end else begin
                low_cnt  = 0;
                bus_hold = 1'($urandom);
                bus_din  = 8'($urandom);
            end
        end
    end

    // Monitor: watches the pins every cycle and retires one expectation per req_ready.
    initial begin : monitor
        int         ads_cnt, rd_cnt, wr_cnt, txn_no;
        logic [7:0] last_rd;
        exp_t       x;
        ads_cnt = 0; rd_cnt = 0; wr_cnt = 0; txn_no = 0; last_rd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
                sb.delete();
                ads_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                last_rd = '0;
            end else if (sb.size() == 0) begin
                chk("idle_quiet", {28'd0, req_ready, ~bus_rd_n, ~bus_wr_n, ~bus_ads_n}, 32'd0);
                chk("doe_idle", {31'd0, bus_doe}, 32'd0);
            end else begin
                x = sb[0];
                if (!bus_ads_n) begin
                    ads_cnt++;
                    chk("addr_at_ads", {16'd0, bus_addr}, {16'd0, x.addr});
                    chk("flags_at_ads", {28'd0, bus_flags}, {28'd0, x.flags});
                    chk("doe_at_ads", {31'd0, bus_doe}, {31'd0, ~x.is_rd});
                    if (!x.is_rd) chk("dout_at_ads", {24'd0, bus_dout}, {24'd0, x.wdata});
                end
                if (!bus_rd_n) rd_cnt++;
                if (!bus_wr_n) wr_cnt++;
                if (!bus_rd_n || !bus_wr_n) begin
                    chk("breq_in_strobe", {31'd0, bus_breq_out}, 32'd1);
                    chk("doe_in_strobe", {31'd0, bus_doe}, {31'd0, ~x.is_rd});
                end
                if (bus_breq_out && bus_ads_n && ads_cnt == 0)
                    chk("enout_in_req", {31'd0, bus_enout}, 32'd0);
                if (req_ready) begin
                    void'(sb.pop_front());
                    if (x.is_rd) last_rd = x.rdata;
                    chk("latency", cyc - x.t0, x.lat);
                    chk("ads_low_clocks", ads_cnt, 1);
                    chk("rd_low_clocks", rd_cnt, x.is_rd ? x.nlow : 0);
                    chk("wr_low_clocks", wr_cnt, x.is_rd ? 0 : x.nlow);
                    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, last_rd});
                    chk("doe_at_done", {31'd0, bus_doe}, {31'd0, ~x.is_rd});
                    chk("breq_at_done", {31'd0, bus_breq_out}, 32'd1);
                    chk("strobes_high_at_done", {30'd0, bus_rd_n, bus_wr_n}, 32'd3);
                    $display("txn %0d %s addr=%04h flags=%h wdata=%02h rdata=%02h lat=%0d low=%0d",
                             txn_no, x.is_rd ? "RD" : "WR", x.addr, x.flags, x.wdata,
                             rsp_rdata, cyc - x.t0, x.is_rd ? rd_cnt : wr_cnt);
                    txn_no++;
                    ads_cnt = 0; rd_cnt = 0; wr_cnt = 0;
                end
            end
        end
    end

    // Issue one bus cycle. e = clocks of ENIN low in REQ; h = hold clocks at strobe end.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [3:0] f, input logic [7:0] wd, input int e,
                           input int h, input bit force_din, input logic [7:0] din_val);
        exp_t x;
        int   n;
        bit   got;
        n = STROBE_CYC + ((HOLD_EN != 0) ? h : 0);
        for (int i = 0; i < 16; i++) din_plan[i] = force_din ? din_val : 8'($urandom);
        hold_plan = h;
        x.is_rd = rd;
        x.rdata = din_plan[n-1];
        x.addr  = a;
        x.flags = f;
        x.wdata = wd;
        x.nlow  = n;
        x.lat   = e + n + 2;
        @(negedge clk);
        chk("enout_idle", {31'd0, bus_enout}, 32'd1);
        x.t0 = cyc + 1;
        sb.push_back(x);
        req_valid = 1'b1; req_rd = rd; req_wr = wr;
        req_addr = a; req_flags = f; req_wdata = wd;
        bus_enin = (e > 0) ? 1'b0 : 1'b1;
        #1;
        chk("enout_on_valid", {31'd0, bus_enout}, 32'd0);
        @(posedge clk);
        repeat (e) @(posedge clk);
        @(negedge clk);
        bus_enin = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("ready_seen", {31'd0, got}, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit found;
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        req_flags = '0; req_addr = '0; req_wdata = '0;
        bus_enin = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd_n", {31'd0, bus_rd_n}, 32'd1);
        chk("rst_wr_n", {31'd0, bus_wr_n}, 32'd1);
        chk("rst_ads_n", {31'd0, bus_ads_n}, 32'd1);
        chk("rst_breq", {31'd0, bus_breq_out}, 32'd0);
        chk("rst_doe", {31'd0, bus_doe}, 32'd0);
        chk("rst_enout", {31'd0, bus_enout}, 32'd0);
        chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_flags", {28'd0, bus_flags}, 32'd0);
        chk("rst_dout", {24'd0, bus_dout}, 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_txn(1'b1, 1'b0, 16'h1234, 4'h1, 8'h00, 0, 0, 1'b1, 8'hA5);
        run_txn(1'b0, 1'b1, 16'h0FFF, 4'h2, 8'h3C, 0, 0, 1'b0, 8'h00);
        run_txn(1'b1, 1'b0, 16'h4000, 4'h4, 8'h00, 4, 0, 1'b0, 8'h00);
        run_txn(1'b1, 1'b0, 16'h8001, 4'h8, 8'h00, 0, 3, 1'b0, 8'h00);
        run_txn(1'b1, 1'b1, 16'hBEEF, 4'hF, 8'h77, 1, 1, 1'b0, 8'h00);

        // A request with no direction is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_rd = 1'b0; req_wr = 1'b0;
        #1;
        chk("enout_ignored_req", {31'd0, bus_enout}, 32'd0);
        repeat (4) @(negedge clk);
        chk("breq_ignored_req", {31'd0, bus_breq_out}, 32'd0);
        req_valid = 1'b0;

        // Random traffic.
        for (int k = 0; k < 30; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_txn((kind != 1), (kind != 0), 16'($urandom), 4'($urandom), 8'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 8'h00);
        end

        // Reset in the middle of a read strobe abandons the cycle.
        begin
            exp_t x;
            for (int i = 0; i < 16; i++) din_plan[i] = 8'($urandom);
            hold_plan = 0;
            x.is_rd = 1'b1; x.rdata = din_plan[0]; x.addr = 16'h5A5A; x.flags = 4'h3;
            x.wdata = 8'h00; x.nlow = STROBE_CYC; x.lat = STROBE_CYC + 2;
            @(negedge clk);
            x.t0 = cyc + 1;
            sb.push_back(x);
            req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0;
            req_addr = 16'h5A5A; req_flags = 4'h3; bus_enin = 1'b1;
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (!bus_rd_n) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("rd_strobe_seen", {31'd0, found}, 32'd1);
            #2;
            rst = 1'b1;
            req_valid = 1'b0;
            #1;
            chk("async_rst_rd_n", {31'd0, bus_rd_n}, 32'd1);
            chk("async_rst_breq", {31'd0, bus_breq_out}, 32'd0);
            chk("async_rst_enout", {31'd0, bus_enout}, 32'd0);
            repeat (2) @(negedge clk);
            chk("post_rst_rdata", {24'd0, rsp_rdata}, 32'd0);
            chk("post_rst_addr", {16'd0, bus_addr}, 32'd0);
            chk("post_rst_flags", {28'd0, bus_flags}, 32'd0);
            rst = 1'b0;
        end

        run_txn(1'b1, 1'b0, 16'h2468, 4'h5, 8'h00, 0, 0, 1'b0, 8'h00);
        run_txn(1'b0, 1'b1, 16'h1357, 4'hA, 8'hC3, 2, 2, 1'b0, 8'h00);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scmp_bus_ctl.md
# scmp_bus_ctl

External bus cycle controller for the SC/MP core. It sits between the microcode sequencer's bus request outputs and the chip pins. It acquires the shared system bus through the BREQ/ENIN/ENOUT daisy chain and sequences the address strobe, read or write strobe and optional hold extension. It stalls the sequencer until the cycle completes and returns read data.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 8: data width.
- `STROBE_CYC`, 2: minimum RD_n/WR_n low time in clocks, ≥1.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `req_valid` in 1: sequencer requests a bus cycle; held until `req_ready`.
- `req_rd` in 1: read cycle.
- `req_wr` in 1: write cycle.
- `req_flags` in 4: {H,D,I,R} status flags.
- `req_addr` in ADDR_W: cycle address.
- `req_wdata` in DATA_W: write data.
- `req_ready` out 1: one-clock pulse, cycle complete.
- `rsp_rdata` out DATA_W: read data, valid with `req_ready`; holds until next read.
- `bus_breq_out` out 1: bus request (drives open-drain BREQ).
- `bus_breq_in` in 1: sampled BREQ line (unused internally except test).
- `bus_enin` in 1: daisy-chain enable in.
- `bus_enout` out 1: daisy-chain enable out.
- `bus_hold` in 1: active-high wait request (NHOLD inverted at pad).
- `bus_ads_n` out 1: address strobe.
- `bus_rd_n` out 1: read strobe.
- `bus_wr_n` out 1: write strobe.
- `bus_addr` out ADDR_W: registered address.
- `bus_flags` out 4: registered flags.
- `bus_dout` out DATA_W: registered write data.
- `bus_doe` out 1: data bus output enable.

## Operation
- States: IDLE, REQ, ADDR, STROBE, WAIT, DONE.
- IDLE: on `req_valid`, latch addr/flags/wdata and direction; go to REQ. Both `req_rd` and `req_wr` set means read. Neither set means the request is ignored.
- REQ: `bus_breq_out`=1. Stay until `bus_enin`=1, then go to ADDR.
- ADDR: `bus_ads_n`=0 for exactly one clock. Address and flags are driven; `bus_doe`=1 if write. Load the strobe counter with STROBE_CYC-1.
- STROBE: `bus_rd_n` or `bus_wr_n`=0. Decrement the counter; at 0, go to WAIT if `bus_hold` else DONE.
- WAIT: strobe stays low while `bus_hold`=1. When `bus_hold`=0, go to DONE.
- Read data is captured from `bus_din` on the final low-strobe clock.
- DONE: strobes high, `req_ready`=1, `bus_breq_out`=1 still. Return to IDLE.
- `bus_breq_out`=1 in REQ through DONE; otherwise 0.
- `bus_enout` = `bus_enin` & (state==IDLE) & ~`req_valid`.
- Once ADDR is entered, `bus_enin` is ignored until IDLE; the bus is owned for the whole cycle.
- `bus_addr`/`bus_flags` hold their last value after the cycle. `bus_doe` is 0 outside ADDR..DONE of a write.
- Reset, at any state: IDLE. All strobes high, `bus_breq_out`=0, `bus_doe`=0, `req_ready`=0, `bus_enout`=0 during reset. `rsp_rdata`, `bus_addr`, `bus_flags` and `bus_dout` are 0. An in-flight cycle is abandoned with no `req_ready`.

## Timing
- All outputs are registered or decoded from state only; no input-to-output combinational path except `bus_enout`.
- Best-case latency, with `bus_enin`=1, no hold, STROBE_CYC=2: request seen in IDLE at clock n. Then REQ n+1, ADDR n+2, STROBE n+3..n+4, DONE n+5 (`req_ready`).
- Each clock of ENIN low in REQ adds one clock.
- Each clock of hold adds one clock.
- Back-to-back: the earliest next request is accepted in IDLE at DONE+1.

## Configuration
- `SCMP_BUS_HOLD_EN` defined: WAIT state and `bus_hold` behave as above.
- Undefined: `bus_hold` is ignored. STROBE goes directly to DONE, and WAIT is unreachable and need not be synthesised.

## Test plan
- Read, ENIN=1, no hold, STROBE_CYC=2, addr 0x1234, flags 0x1, `bus_din`=0xA5 → ADS_n low 1 clock, RD_n low 2 clocks, `req_ready` at n+5, `rsp_rdata`=0xA5.
- Write 0x3C to 0x0FFF → WR_n low 2 clocks, `bus_dout`=0x3C and `bus_doe`=1 from ADDR through DONE, `bus_doe`=0 after.
- ENIN held low 4 clocks in REQ → BREQ high throughout, `bus_enout`=0, ADS_n delayed by exactly 4 clocks.
- With `SCMP_BUS_HOLD_EN`, hold=1 for 3 clocks at strobe end → RD_n low 5 clocks, data sampled on last. Without the macro: low 2 clocks.
- Idle with ENIN=1 and no request → `bus_enout`=1. Raise `req_valid` → `bus_enout`=0 in the same clock.
- Assert `rst` during STROBE → RD_n and BREQ high immediately, no `req_ready`. A new read after release completes normally.
